// File: rtl/i2c_bit_sequencer_if.sv
// i2c_bit_sequencer_if: command/response handshake and pad signals between the byte FSM, the bit sequencer and the open-drain pads.
interface i2c_bit_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic       cmd_wbit;
    logic       rsp_valid;
    logic       rsp_rbit;
    logic       busy;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    modport slave (
        input  cmd_valid, cmd, cmd_wbit, scl_in, sda_in,
        output cmd_ready, rsp_valid, rsp_rbit, busy, scl_oe, sda_oe
    );
    modport master (
        output cmd_valid, cmd, cmd_wbit, scl_in, sda_in,
        input  cmd_ready, rsp_valid, rsp_rbit, busy, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_bit_sequencer.sv
// i2c_bit_sequencer: drives one I2C primitive (START/STOP/WRITE/READ) as four DIVIDE-cycle quarter-bit phases.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching in phase 1.
module i2c_bit_sequencer #(
    parameter int DIVIDE = 125
) (
    input logic                  clk_in,
    input logic                  rst_n,
    i2c_bit_sequencer_if.slave   bus
);
    localparam int CW = (DIVIDE < 2) ? 1 : $clog2(DIVIDE);
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_STOP  = 2'd1;
    localparam logic [1:0] C_WRITE = 2'd2;

    generate
        if (DIVIDE < 2) begin : g_bad_divide
            $error("DIVIDE must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      phase_q;
    logic [1:0]      cmd_q;
    logic            wbit_q;
    logic            samp_q;
    logic            ready_q;
    logic            busy_q;
    logic            rsp_valid_q;
    logic            rsp_rbit_q;
    logic            scl_oe_q;
    logic            sda_oe_q;
    logic            scl_d;
    logic            sda_d;
    logic            tc_d;
    logic            hold_d;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], bus.scl_in};
    end
    // Phase 1 timing starts only once the released SCL is actually seen high.
    assign hold_d = (phase_q == 2'd1) && (cnt_q == '0) && !sync_q[1];
`else
    assign hold_d = 1'b0;
`endif

    always_comb begin
        tc_d  = cnt_q == CW'(DIVIDE - 1);
        scl_d = (cmd_q == C_START) ? (phase_q == 2'd3) :
                (cmd_q == C_STOP)  ? (phase_q == 2'd0) :
                                     (phase_q == 2'd0 || phase_q == 2'd3);
        sda_d = (cmd_q == C_START) ? (phase_q != 2'd0) :
                (cmd_q == C_STOP)  ? (phase_q != 2'd3) :
                (cmd_q == C_WRITE) ? ~wbit_q : 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 2'd0;
            cmd_q       <= 2'd0;
            wbit_q      <= 1'b0;
            samp_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rbit_q  <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.cmd_valid) begin
                    state_q <= RUN;
                    cmd_q   <= bus.cmd;
                    wbit_q  <= bus.cmd_wbit;
                    cnt_q   <= '0;
                    phase_q <= 2'd0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end else begin
                scl_oe_q <= scl_d;
                sda_oe_q <= sda_d;
                cnt_q    <= hold_d ? cnt_q : tc_d ? '0 : cnt_q + 1'b1;
                phase_q  <= (!hold_d && tc_d) ? phase_q + 2'd1 : phase_q;
                if (phase_q == 2'd2 && tc_d) samp_q <= bus.sda_in;
                if (phase_q == 2'd3 && tc_d) begin
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_rbit_q  <= cmd_q[1] & samp_q;
                end
            end
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rbit  = rsp_rbit_q;
    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;
endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// tb_i2c_bit_sequencer: table-driven command vectors with a response scoreboard, plus reset and clock-stretch sequences.
module tb_i2c_bit_sequencer;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_bit_sequencer_if bus();
    i2c_bit_sequencer #(.DIVIDE(D)) dut (.clk_in(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [1:0] c;
        logic       w;
        logic       s;
        logic [3:0] scl;
        logic [3:0] sda;
        logic       rbit;
        logic       chain;
    } vec_t;

    vec_t vt[9];
    logic exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    // Scoreboard: each completion pops the rbit pushed when its command was issued.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            check("sb_has_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rsp_rbit", bus.rsp_rbit, exp_q.pop_front());
        end
    end

    task automatic do_cmd(input vec_t v, input bit pads, input int lmin, input int lmax, input int rise_k);
        int k;
        if (!v.chain) begin
            @(posedge clk);
            #1;
        end
        check("ready_before", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd       = v.c;
        bus.cmd_wbit  = v.w;
        bus.sda_in    = v.s;
        exp_q.push_back(v.rbit);
        @(posedge clk);
        #1;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (k == 0) begin
                check("busy_run", bus.busy, 1);
                check("ready_run", bus.cmd_ready, 0);
            end
            if (pads && (k % D) == 2 && k < 4 * D) begin
                check("scl_phase", bus.scl_oe, v.scl[k / D]);
                check("sda_phase", bus.sda_oe, v.sda[k / D]);
            end
            if (bus.rsp_valid || k >= 100) break;
            bus.cmd      = 2'($urandom);
            bus.cmd_wbit = 1'($urandom);
            if (k == rise_k) bus.scl_in = 1'b1;
            if (k == lmin - 1) bus.cmd_valid = 1'b0;
            k++;
        end
        total++;
        if (k < lmin || k > lmax) begin
            bad++;
            $display("FAIL latency: got %0d want %0d..%0d", k, lmin, lmax);
        end
    endtask

    initial begin
        vt[0] = '{2'd0, 1'b0, 1'b1, 4'b1000, 4'b1110, 1'b0, 1'b0};
        vt[1] = '{2'd1, 1'b0, 1'b1, 4'b0001, 4'b0111, 1'b0, 1'b1};
        vt[2] = '{2'd2, 1'b0, 1'b0, 4'b1001, 4'b1111, 1'b0, 1'b0};
        vt[3] = '{2'd3, 1'b0, 1'b1, 4'b1001, 4'b0000, 1'b1, 1'b0};
        vt[4] = '{2'd3, 1'b1, 1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0};
        vt[5] = '{2'd2, 1'b1, 1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1};
        vt[6] = '{2'd3, 1'b0, 1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1};
        vt[7] = '{2'd0, 1'b1, 1'b0, 4'b1000, 4'b1110, 1'b0, 1'b0};
        vt[8] = '{2'd1, 1'b1, 1'b1, 4'b0001, 4'b0111, 1'b0, 1'b1};
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'd0;
        bus.cmd_wbit  = 1'b0;
        bus.scl_in    = 1'b1;
        bus.sda_in    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scl", bus.scl_oe, 0);
        check("rst_sda", bus.sda_oe, 0);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp", bus.rsp_valid, 0);
        check("rst_rbit", bus.rsp_rbit, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", bus.cmd_ready, 1);
        check("idle_rsp", bus.rsp_valid, 0);

        for (int i = 0; i < 9; i++) do_cmd(vt[i], 1'b1, 4 * D, 4 * D, -1);
        repeat (3) @(negedge clk);
        check("stop_scl_rel", bus.scl_oe, 0);
        check("stop_sda_rel", bus.sda_oe, 0);

        // Slave holds SCL low into phase 1 of a WRITE.
        bus.scl_in = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
        do_cmd('{2'd2, 1'b0, 1'b1, 4'b1001, 4'b1111, 1'b1, 1'b0}, 1'b0, 4 * D + 20, 4 * D + 22, D + 19);
`else
        do_cmd('{2'd2, 1'b0, 1'b1, 4'b1001, 4'b1111, 1'b1, 1'b0}, 1'b0, 4 * D, 4 * D, D + 19);
`endif
        bus.scl_in = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_rbit", bus.rsp_rbit, 1);
        check("hold_scl", bus.scl_oe, 1);
        check("hold_sda", bus.sda_oe, 1);
        check("hold_ready", bus.cmd_ready, 1);

        // Asynchronous reset in the middle of a WRITE releases the pads at once.
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = 2'd2;
        bus.cmd_wbit  = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_scl_low", bus.scl_oe, 1);
        rst_n = 1'b0;
        #1;
        check("arst_scl", bus.scl_oe, 0);
        check("arst_sda", bus.sda_oe, 0);
        check("arst_ready", bus.cmd_ready, 1);
        check("arst_busy", bus.busy, 0);
        check("arst_rsp", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_cmd(vt[3], 1'b1, 4 * D, 4 * D, -1);
        repeat (40) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
